// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter for a single UART transmit byte channel.
// Grants one byte at a time to either the manual sender or the script
// sender, then strobes it to the UART and waits a fixed byte-time gap,
// since the UART has no busy indication of its own. New grants are
// suppressed while a script is being loaded.
module uart_tx_arbiter #(
   parameter int unsigned BYTE_GAP = 176,  // idle cycles after each strobe, >= 1
   parameter bit          SHARE    = 1'b0  // 1: non-owner may use idle slots
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load_busy,
   input  logic       owner_script,
   input  logic       man_valid,
   input  logic [7:0] man_bits,
   output logic       man_ack,
   input  logic       scr_valid,
   input  logic [7:0] scr_bits,
   output logic       scr_ack,
   output logic [7:0] tx_bits,
   output logic       tx_valid,
   output logic       tx_busy,
   output logic [7:0] man_cnt,
   output logic [7:0] scr_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam int unsigned      GAP_W    = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(BYTE_GAP - 1);

   logic [1:0]       state;
   logic [GAP_W-1:0] gap_cnt;
   logic             sel_scr;   // requester whose byte is in flight
   logic             pick_man;
   logic             pick_scr;

   // Arbitration in IDLE: owner first, the other only when sharing is enabled.
   // Gated by reset so no request is acknowledged on a cycle that is discarded.
   always_comb begin
      pick_man = 1'b0;
      pick_scr = 1'b0;
      if (state == ST_IDLE && !reset && !load_busy) begin
         if (owner_script) begin
            if (scr_valid)
               pick_scr = 1'b1;
            else if (SHARE && man_valid)
               pick_man = 1'b1;
         end else begin
            if (man_valid)
               pick_man = 1'b1;
            else if (SHARE && scr_valid)
               pick_scr = 1'b1;
         end
      end
   end

   assign man_ack  = pick_man;
   assign scr_ack  = pick_scr;
   assign tx_valid = (state == ST_SEND);
   assign tx_busy  = (state == ST_SEND) || (state == ST_GAP);

   // Sequencer: latch granted byte, strobe once, count it, then hold off BYTE_GAP cycles.
   // tx_bits doubles as the hold register, so it only changes on a grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         gap_cnt <= '0;
         sel_scr <= 1'b0;
         tx_bits <= '0;
         man_cnt <= '0;
         scr_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_man || pick_scr) begin
                  tx_bits <= pick_scr ? scr_bits : man_bits;
                  sel_scr <= pick_scr;
                  state   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (sel_scr)
                  scr_cnt <= scr_cnt + 8'd1;
               else
                  man_cnt <= man_cnt + 8'd1;
               gap_cnt <= GAP_LOAD;
               state   <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt == '0)
                  state <= ST_IDLE;
               else
                  gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter. Two instances share
// the same stimulus, one exclusive (SHARE=0) and one sharing (SHARE=1),
// each compared every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

   localparam int BG = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load_busy = 1'b0;
   logic       owner_script = 1'b0;
   logic       man_valid = 1'b0;
   logic [7:0] man_bits = 8'h00;
   logic       scr_valid = 1'b0;
   logic [7:0] scr_bits = 8'h00;

   logic       man_ack_o  [2];
   logic       scr_ack_o  [2];
   logic [7:0] tx_bits_o  [2];
   logic       tx_valid_o [2];
   logic       tx_busy_o  [2];
   logic [7:0] man_cnt_o  [2];
   logic [7:0] scr_cnt_o  [2];

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_arbiter #(.BYTE_GAP(BG), .SHARE(1'b0)) u_excl (
      .clock(clock), .reset(reset), .load_busy(load_busy), .owner_script(owner_script),
      .man_valid(man_valid), .man_bits(man_bits), .man_ack(man_ack_o[0]),
      .scr_valid(scr_valid), .scr_bits(scr_bits), .scr_ack(scr_ack_o[0]),
      .tx_bits(tx_bits_o[0]), .tx_valid(tx_valid_o[0]), .tx_busy(tx_busy_o[0]),
      .man_cnt(man_cnt_o[0]), .scr_cnt(scr_cnt_o[0]));

   uart_tx_arbiter #(.BYTE_GAP(BG), .SHARE(1'b1)) u_share (
      .clock(clock), .reset(reset), .load_busy(load_busy), .owner_script(owner_script),
      .man_valid(man_valid), .man_bits(man_bits), .man_ack(man_ack_o[1]),
      .scr_valid(scr_valid), .scr_bits(scr_bits), .scr_ack(scr_ack_o[1]),
      .tx_bits(tx_bits_o[1]), .tx_valid(tx_valid_o[1]), .tx_busy(tx_busy_o[1]),
      .man_cnt(man_cnt_o[1]), .scr_cnt(scr_cnt_o[1]));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: each grant makes the channel busy for 1 + BG cycles,
   // the first of which is the strobe carrying the granted byte.
   int         m_busy   [2];
   logic [7:0] m_last   [2];
   logic [7:0] m_mcnt   [2];
   logic [7:0] m_scnt   [2];
   logic       m_sel    [2];
   int         m_lastst [2];
   int         cyc = 0;
   bit         chk_en = 1'b0;
   logic       man_acked = 1'b0;
   logic       scr_acked = 1'b0;

   always @(negedge clock) begin
      logic e_ma, e_sa, e_txv;
      for (int k = 0; k < 2; k++) begin
         e_ma  = 1'b0;
         e_sa  = 1'b0;
         e_txv = (m_busy[k] == BG + 1);
         if (m_busy[k] == 0 && !reset && !load_busy) begin
            if (owner_script) begin
               if (scr_valid) e_sa = 1'b1;
               else if (k == 1 && man_valid) e_ma = 1'b1;
            end else begin
               if (man_valid) e_ma = 1'b1;
               else if (k == 1 && scr_valid) e_sa = 1'b1;
            end
         end
         if (chk_en) begin
            check($sformatf("tx_valid[%0d]", k), tx_valid_o[k], e_txv);
            check($sformatf("tx_busy[%0d]", k), tx_busy_o[k], m_busy[k] > 0);
            check($sformatf("tx_bits[%0d]", k), tx_bits_o[k], m_last[k]);
            check($sformatf("man_ack[%0d]", k), man_ack_o[k], e_ma);
            check($sformatf("scr_ack[%0d]", k), scr_ack_o[k], e_sa);
            check($sformatf("man_cnt[%0d]", k), man_cnt_o[k], m_mcnt[k]);
            check($sformatf("scr_cnt[%0d]", k), scr_cnt_o[k], m_scnt[k]);
            if (tx_valid_o[k] === 1'b1) begin
               check($sformatf("spacing_ok[%0d]", k), (cyc - m_lastst[k]) >= BG + 2, 1);
               m_lastst[k] = cyc;
            end
         end
         if (reset) begin
            m_busy[k]   = 0;
            m_last[k]   = 8'h00;
            m_mcnt[k]   = 8'h00;
            m_scnt[k]   = 8'h00;
            m_sel[k]    = 1'b0;
            m_lastst[k] = -1000;
         end else begin
            if (e_txv) begin
               if (m_sel[k]) m_scnt[k] = m_scnt[k] + 8'd1;
               else          m_mcnt[k] = m_mcnt[k] + 8'd1;
            end
            if (m_busy[k] > 0) m_busy[k] = m_busy[k] - 1;
            if (e_ma || e_sa) begin
               m_busy[k] = BG + 1;
               m_last[k] = e_sa ? scr_bits : man_bits;
               m_sel[k]  = e_sa;
            end
         end
      end
      man_acked = man_ack_o[0] | man_ack_o[1];
      scr_acked = scr_ack_o[0] | scr_ack_o[1];
      if (reset) chk_en = 1'b1;
      cyc++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int  waited;
      bit  hit;

      // Reset, then manual owner with a continuous request.
      run(2);
      reset = 1'b0;
      tick();
      man_valid = 1'b1;
      man_bits  = 8'hA5;
      run(10);

      // Script owner with both requesting: owner served exclusively.
      owner_script = 1'b1;
      scr_valid    = 1'b1;
      scr_bits     = 8'h3C;
      run(20);

      // Script owner idle, manual requests; sharing instance serves it, then script.
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      scr_valid = 1'b0;
      man_valid = 1'b1;
      man_bits  = 8'h11;
      hit = 1'b0;
      for (waited = 0; waited < 20 && !hit; waited++) begin
         tick();
         if (man_acked) hit = 1'b1;
      end
      check("share_grant_seen", hit, 1);
      man_valid = 1'b0;
      run(2);
      scr_valid = 1'b1;
      scr_bits  = 8'h5A;
      run(12);

      // Loading blocks everything; release grants immediately.
      load_busy = 1'b1;
      man_valid = 1'b1;
      man_bits  = 8'h77;
      run(50);
      load_busy = 1'b0;
      run(10);

      // Reset in the third gap cycle.
      owner_script = 1'b0;
      hit = 1'b0;
      for (waited = 0; waited < 20 && !hit; waited++) begin
         tick();
         if (tx_valid_o[0]) hit = 1'b1;
      end
      check("strobe_before_reset", hit, 1);
      run(3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      run(6);

      // 257+ manual bytes with fresh data after each acceptance.
      scr_valid = 1'b0;
      for (int i = 0; i < 260 * (BG + 2); i++) begin
         tick();
         if (man_acked) man_bits = 8'($urandom);
      end

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         tick();
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) owner_script = ~owner_script;
         if ($urandom_range(0, 9) == 0) load_busy = ($urandom_range(0, 3) == 0);
         if (!man_valid || man_acked) begin
            man_valid = $urandom_range(0, 1) == 1;
            man_bits  = 8'($urandom);
         end else if ($urandom_range(0, 19) == 0) begin
            man_valid = 1'b0;
         end
         if (!scr_valid || scr_acked) begin
            scr_valid = $urandom_range(0, 1) == 1;
            scr_bits  = 8'($urandom);
         end else if ($urandom_range(0, 19) == 0) begin
            scr_valid = 1'b0;
         end
      end

      reset = 1'b0;
      run(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
